// File: rtl/pc_unit_if.sv
// Bundle of redirect/stall requests into the PC unit and its status outputs.
interface pc_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             trap;
  logic [XLEN-1:0]  trap_vec;
  logic             mret;
  logic [XLEN-1:0]  mepc;
  logic             redir_ex;
  logic [XLEN-1:0]  redir_ex_addr;
  logic             hold;
  logic             fetch_stall;
  logic             mem_stall;
  logic [XLEN-1:0]  pc_out;
  logic             redir_pend;
  logic             misalign;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline control side: raises requests, observes the fetch address.
  modport master (
    output trap, trap_vec, mret, mepc, redir_ex, redir_ex_addr,
           hold, fetch_stall, mem_stall,
    input  pc_out, redir_pend, misalign, stall_cnt
  );

  // PC unit side.
  modport slave (
    input  trap, trap_vec, mret, mepc, redir_ex, redir_ex_addr,
           hold, fetch_stall, mem_stall,
    output pc_out, redir_pend, misalign, stall_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with prioritised redirects, stall-safe redirect latching,
// misalignment flag and saturating stall-cycle counter.
module pc_unit #(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned    STEP      = 4,
  parameter int unsigned    CNT_W     = 16
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  // Ordered so that a numerically larger value wins; NONE marks "empty".
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_EX   = 2'd1,
    PRI_MRET = 2'd2,
    PRI_TRAP = 2'd3
  } pri_e;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pend_tgt;
  pri_e             r_pend_pri;
  logic             r_misalign;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  pri_e             w_live_pri;
  logic [XLEN-1:0]  w_live_tgt;

  // Select the winning live redirect: trap > mret > EX branch.
  always_comb begin
    w_stall    = bus.fetch_stall | bus.mem_stall;
    w_live_pri = PRI_NONE;
    w_live_tgt = '0;
    if (bus.trap) begin
      w_live_pri = PRI_TRAP;
      w_live_tgt = bus.trap_vec;
    end else if (bus.mret) begin
      w_live_pri = PRI_MRET;
      w_live_tgt = bus.mepc;
    end else if (bus.redir_ex) begin
      w_live_pri = PRI_EX;
      w_live_tgt = bus.redir_ex_addr;
    end
  end

  // PC update, pending-redirect latch, misalign flag and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_VEC;
      r_pend_tgt  <= '0;
      r_pend_pri  <= PRI_NONE;
      r_misalign  <= 1'b0;
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      if (r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      // An empty pending slot has PRI_NONE, so this also covers first capture;
      // equal priority overwrites so the newest request survives.
      if (w_live_pri != PRI_NONE && w_live_pri >= r_pend_pri) begin
        r_pend_pri <= w_live_pri;
        r_pend_tgt <= w_live_tgt;
      end
    end else if (w_live_pri != PRI_NONE) begin
      r_pc       <= {w_live_tgt[XLEN-1:2], 2'b00};
      r_misalign <= |w_live_tgt[1:0];
      r_pend_pri <= PRI_NONE;
    end else if (r_pend_pri != PRI_NONE) begin
      r_pc       <= {r_pend_tgt[XLEN-1:2], 2'b00};
      r_misalign <= |r_pend_tgt[1:0];
      r_pend_pri <= PRI_NONE;
    end else if (!bus.hold) begin
      r_pc <= r_pc + XLEN'(STEP);
    end
  end

  assign bus.pc_out     = r_pc;
  assign bus.redir_pend = (r_pend_pri != PRI_NONE);
  assign bus.misalign   = r_misalign;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule
